// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants: exception codes, fetch window, reset PC, nop
package cpu_defs_pkg;

   localparam logic [4:0]  EXC_NONE         = 5'd0;
   localparam logic [4:0]  EXC_ADEL         = 5'd4;

   localparam logic [31:0] IM_LO_DEFAULT    = 32'h0000_3000;
   localparam logic [31:0] IM_HI_DEFAULT    = 32'h0000_6FFC;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/fetch_exc_check.sv
// rtl/fetch_exc_check.sv - combinational AdEL detector for a word-aligned address window
module fetch_exc_check
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] IM_LO = IM_LO_DEFAULT,
   parameter logic [31:0] IM_HI = IM_HI_DEFAULT
)(
   input  logic [31:0] i_addr,
   output logic        o_fault,
   output logic [4:0]  o_exc_code
);

   logic w_misaligned;
   logic w_out_of_range;

   // Misalignment or an address outside [IM_LO, IM_HI] (unsigned, full width) raises AdEL
   always_comb begin
      w_misaligned   = (i_addr[1:0] != 2'b00);
      w_out_of_range = (i_addr < IM_LO) || (i_addr > IM_HI);
      o_fault        = w_misaligned || w_out_of_range;
      o_exc_code     = o_fault ? EXC_ADEL : EXC_NONE;
   end

endmodule

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with AdEL tagging and BD flag; optional IF_ID_STALL_CNT_EN adds stall_cnt
module if_id_reg
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter logic [31:0] IM_LO    = IM_LO_DEFAULT,
   parameter logic [31:0] IM_HI    = IM_HI_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        IntReq,
   input  logic        flush,
   input  logic        is_jump_D,
   input  logic [31:0] PC_F,
   input  logic [31:0] PC4_F,
   input  logic [31:0] Instr_F,
   output logic [31:0] IR_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC4_D,
   output logic [4:0]  ExcCode_D,
   output logic        BD_D
`ifdef IF_ID_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic       w_fault;
   logic [4:0] w_exc_code;

   fetch_exc_check #(
      .IM_LO (IM_LO),
      .IM_HI (IM_HI)
   ) u_fetch_exc_check (
      .i_addr     (PC_F),
      .o_fault    (w_fault),
      .o_exc_code (w_exc_code)
   );

   // Pipeline register: reset > interrupt > flush > stall > load; flushes keep the live PC for EPC
   always_ff @(posedge clk) begin
      if (reset) begin
         IR_D      <= NOP;
         PC_D      <= PC_RESET;
         PC4_D     <= PC_RESET + 32'd4;
         ExcCode_D <= EXC_NONE;
         BD_D      <= 1'b0;
      end else if (IntReq || flush) begin
         IR_D      <= NOP;
         PC_D      <= PC_F;
         PC4_D     <= PC4_F;
         ExcCode_D <= EXC_NONE;
         BD_D      <= 1'b0;
      end else if (en) begin
         IR_D      <= w_fault ? NOP : Instr_F;
         PC_D      <= PC_F;
         PC4_D     <= PC4_F;
         ExcCode_D <= w_exc_code;
         BD_D      <= is_jump_D;
      end
   end

`ifdef IF_ID_STALL_CNT_EN
   // Count genuine stall edges only; interrupts and flushes do not clear the count
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= 32'd0;
      end else if (!IntReq && !flush && !en) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the fetch stage and decode in the P7 five-stage MIPS CPU with CP0 interrupts.
- Latches the fetch PC, PC+4 and the instruction-memory word each cycle.
- Detects fetch address exceptions (AdEL) and tags branch-delay-slot instructions (BD) for CP0.
- Honours stall, eret-flush and interrupt-flush so decode always sees a consistent macroscopic PC.

Parameters:
- PC_RESET, 32'h0000_3000, reset value of PC_D (PC4_D resets to PC_RESET+4).
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  load enable; 0 = stall (hold contents).
- IntReq  input  1  CP0 interrupt/exception request; flushes register.
- flush  input  1  eret/branch-squash flush from decode.
- is_jump_D  input  1  instruction currently in decode is a branch/jump; the word being fetched is its delay slot.
- PC_F  input  32  fetch PC from IF (PC_out).
- PC4_F  input  32  fetch PC+4 from IF.
- Instr_F  input  32  instruction-memory read data for PC_F.
- IR_D  output  32  instruction to decode.
- PC_D  output  32  PC of IR_D.
- PC4_D  output  32  PC_D+4.
- ExcCode_D  output  5  0 = none, 4 = AdEL on fetch.
- BD_D  output  1  IR_D is in a branch delay slot.

Behaviour:
- All state updates on rising clk only. The outputs are registers with no combinational input-to-output path. Latency is 1 cycle.
- Reset values: IR_D = 0, PC_D = PC_RESET, PC4_D = PC_RESET+4, ExcCode_D = 0, BD_D = 0.
- Priority per edge, highest first:
  1. reset → reset values.
  2. IntReq → IR_D = 0 (nop), ExcCode_D = 0, BD_D = 0, PC_D = PC_F, PC4_D = PC4_F. IntReq overrides en = 0, so a stall cannot mask an interrupt.
  3. flush → same as IntReq (nop with live PC).
  4. en = 0 → hold all outputs unchanged.
  5. en = 1 → load. BD_D = is_jump_D. The remaining fields follow the AdEL check.
- AdEL check (combinational on PC_F, used only when loading):
  - Fault when PC_F[1:0] != 0, PC_F < IM_LO, or PC_F > IM_HI. Unsigned compare, full 32 bits.
  - On fault: ExcCode_D = 4, IR_D = 0, PC_D = PC_F (becomes EPC), PC4_D = PC4_F, BD_D = is_jump_D.
  - No fault: ExcCode_D = 0, IR_D = Instr_F.
- Boundaries:
  - PC_F = IM_HI is legal; IM_HI+4 faults.
  - PC_F = 0xFFFF_FFFC faults with no wrap issue. PC4_F is passed through unchecked.
  - Stall held for N cycles: outputs bit-identical for all N cycles.
  - flush and en = 0 together: flush wins.
  - reset mid-stall: reset values on the next edge.

Optional Feature:
- Macro IF_ID_STALL_CNT_EN.
- When defined:
  - Extra output stall_cnt [31:0] counts edges where en = 0 and no reset, IntReq or flush is active.
  - Reset to 0 by reset. Wraps 0xFFFF_FFFF → 0.
  - Not cleared by IntReq or flush.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header cpu_defs:
  - EXC_NONE = 5'd0 and EXC_ADEL = 5'd4.
  - IM_LO / IM_HI defaults.
  - PC_RESET.
  - NOP = 32'h0.
- One natural sub-module: fetch_exc_check, a combinational AdEL detector (PC_F → fault, ExcCode), reusable by the MEM-stage load check.

Test Plan:
- Reset: assert reset 1 cycle with en = 1, PC_F = 0x3010 → IR_D = 0, PC_D = 0x3000, PC4_D = 0x3004, ExcCode_D = 0, BD_D = 0.
- Normal flow: PC_F = 0x3000, Instr_F = 0x3C011234, en = 1, is_jump_D = 0 → next cycle IR_D = 0x3C011234, PC_D = 0x3000, BD_D = 0. Repeat with is_jump_D = 1 → BD_D = 1.
- Stall: load 0x3004/0x8C220000, then en = 0 for 3 cycles while inputs change to 0x3008/0xFFFFFFFF → outputs stay 0x3004/0x8C220000 throughout.
- AdEL:
  - PC_F = 0x3002 → ExcCode_D = 4, IR_D = 0, PC_D = 0x3002.
  - PC_F = 0x7000 → ExcCode_D = 4.
  - PC_F = 0x6FFC → ExcCode_D = 0.
- Interrupt during stall: en = 0, IntReq = 1, PC_F = 0x3020 → IR_D = 0, PC_D = 0x3020, ExcCode_D = 0, BD_D = 0.
- flush with is_jump_D = 1 and en = 1 → IR_D = 0, BD_D = 0, PC_D = PC_F. With IF_ID_STALL_CNT_EN defined, 5 plain stall cycles → stall_cnt = 5.
